ring_sweeper: RTL and testbench
===============================

Name: ring_sweeper

Overview:
- Consumer for the streaming read side of the frequency ring buffer.
- Pops one tone word at a time via the ring's ready/rd_en handshake and holds it on the DDS tone output for a programmable dwell (clk cycles).
- Advances through the ring in order, either continuously (wraps at last) or as a single pass ending in a done pulse.
- Sits between the ring buffer and the DDS tone-control register.

Parameters:
DATA_W, 14, tone word width (matches ring dout)
ADDR_W, 7, ring index width
CNT_W, 8, ring entry count width
DWELL_W, 16, dwell counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  level; 1 = run sweep, 0 = stop
single  in  1  1 = one pass then stop, 0 = continuous; sampled at start
dwell  in  DWELL_W  hold cycles per tone; sampled at each LOAD; 0 treated as 1
ring_dout  in  DATA_W  ring front entry
ring_ready  in  1  ring front entry valid
ring_index  in  ADDR_W  ring index of front entry
ring_count  in  CNT_W  number of entries written to ring
ring_last  in  1  front entry is last in ring
ring_rd_en  out  1  one-cycle pop request to ring
tone  out  DATA_W  current tone word to DDS
tone_index  out  ADDR_W  ring index of current tone
tone_valid  out  1  tone output meaningful
tone_strobe  out  1  one-cycle pulse when a new tone is loaded
sweep_done  out  1  one-cycle pulse at end of single pass
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, immediate): state IDLE; tone=0, tone_index=0, tone_valid=0, tone_strobe=0, sweep_done=0, ring_rd_en=0, busy=0; dwell counter=0.
- States: IDLE, WAIT, LOAD, DWELL, POP, SETTLE.
- IDLE: enable=1 and ring_count!=0 -> WAIT; latch single into single_q.
- WAIT: ring_ready=1 -> LOAD; otherwise hold. Covers ring refill after a write and random-access occupancy.
- LOAD (1 cycle):
  - tone<=ring_dout, tone_index<=ring_index, last_q<=ring_last, tone_valid<=1, tone_strobe pulses.
  - dwell_cnt<=max(dwell,1).
  - -> DWELL.
- DWELL:
  - dwell_cnt decrements each cycle.
  - At dwell_cnt==1: if single_q and last_q -> pulse sweep_done, tone_valid<=0, -> IDLE; else -> POP.
  - Tone hold per entry = dwell+3 cycles (LOAD, DWELL, POP, SETTLE), plus any WAIT cycles.
- POP:
  - ring_rd_en=1 for exactly one cycle only if ring_ready=1, then -> SETTLE.
  - If ring_ready=0: no pop, -> WAIT. Ring was reset by a write; restart from its new front.
- SETTLE: one idle cycle so the ring front register updates before resampling; -> WAIT.
- ring_rd_en is never asserted outside POP and never on consecutive cycles.
- enable=0 in any state -> IDLE next cycle. tone_valid<=0, no rd_en that cycle, no sweep_done. tone/tone_index keep last value.
- ring_count==0 while running: stay in or return to WAIT, hold tone_valid. Resume when ring_ready rises.
- Continuous mode: ring_last is ignored for termination. The ring itself wraps to index 0 after last.
- Simultaneous enable=0 and end-of-dwell: enable wins; no pop, no done.
- dwell change mid-DWELL has no effect until next LOAD.

Optional Feature:
- Macro: RING_SWEEPER_PAUSE_EN.
- With macro: adds input pause (1 bit).
  - pause=1 freezes dwell_cnt in DWELL and blocks the transition out of WAIT.
  - Outputs hold, tone_valid stays 1, no rd_en.
  - Deasserting pause resumes exactly where frozen.
- Without macro: no pause port; behaviour as above.

Decomposition:
- Package ring_sweeper_pkg:
  - state enum (IDLE, WAIT, LOAD, DWELL, POP, SETTLE).
  - Localparams DATA_W=14, ADDR_W=7, CNT_W=8, DWELL_W=16, shared with ring buffer instantiation.
- Sub-module dwell_timer:
  - Inputs: load, value, (pause).
  - Behaviour: down-counter with zero-as-one clamp; outputs expire at count 1.

Test Plan:
- Ring preloaded with 4 entries (0x100,0x200,0x300,0x400), single=1, dwell=5, enable=1 -> 4 tone_strobe pulses, consecutive spacing 8 cycles with ready held high, tones in order, indices 0..3; 3 rd_en pulses; sweep_done once after last dwell; tone_valid falls with done.
- Same ring, single=0, dwell=2, run 12 strobes -> index sequence 0,1,2,3,0,1,...; no sweep_done.
- dwell=0 -> behaves as dwell=1, strobe spacing 4 cycles.
- Deassert enable during DWELL of entry 2 -> IDLE next cycle; tone_valid=0; no rd_en; tone holds 0x300.
- Drop ring_ready at POP (simulated ring write reset) -> no rd_en; FSM waits in WAIT; reload from new front when ready returns, tone_index=0.
- Assert rst mid-DWELL -> all outputs 0 in the same cycle (async); after release, FSM is in IDLE until enable.

Source files
------------

// File: rtl/ring_sweeper_pkg.sv
// ----------------------------------------------------------------------------
// ring_sweeper_pkg
// Shared widths, FSM state encoding and helpers for the ring sweeper and the
// frequency ring buffer it reads from.
//   DATA_W  : tone word width (matches ring dout)
//   ADDR_W  : ring index width
//   CNT_W   : ring entry count width
//   DWELL_W : dwell counter width
// ----------------------------------------------------------------------------
package ring_sweeper_pkg;

    localparam int DATA_W  = 14;
    localparam int ADDR_W  = 7;
    localparam int CNT_W   = 8;
    localparam int DWELL_W = 16;

    typedef enum logic [2:0] {
        SWEEP_IDLE   = 3'd0,
        SWEEP_WAIT   = 3'd1,
        SWEEP_LOAD   = 3'd2,
        SWEEP_DWELL  = 3'd3,
        SWEEP_POP    = 3'd4,
        SWEEP_SETTLE = 3'd5
    } sweep_state_e;

    // Plain vector constants so the state register stays an ordinary logic
    // vector that older tools and netlist viewers handle without enum support.
    localparam logic [2:0] ST_IDLE   = SWEEP_IDLE;
    localparam logic [2:0] ST_WAIT   = SWEEP_WAIT;
    localparam logic [2:0] ST_LOAD   = SWEEP_LOAD;
    localparam logic [2:0] ST_DWELL  = SWEEP_DWELL;
    localparam logic [2:0] ST_POP    = SWEEP_POP;
    localparam logic [2:0] ST_SETTLE = SWEEP_SETTLE;

    // A dwell of zero would never expire in a down-counter, so it is run as 1.
    function automatic logic [DWELL_W-1:0] clampDwell(input logic [DWELL_W-1:0] value);
        return (value == '0) ? DWELL_W'(1) : value;
    endfunction

endpackage

// File: rtl/ring_sweeper_if.sv
// ----------------------------------------------------------------------------
// ring_sweeper_if
// Streaming read side of the frequency ring buffer.
//   ring_dout  : front entry tone word          (ring -> sweeper)
//   ring_ready : front entry valid              (ring -> sweeper)
//   ring_index : ring index of the front entry  (ring -> sweeper)
//   ring_count : number of entries written      (ring -> sweeper)
//   ring_last  : front entry is the last entry  (ring -> sweeper)
//   ring_rd_en : one-cycle pop request          (sweeper -> ring)
// Modports: master = ring buffer side, slave = sweeper side.
// ----------------------------------------------------------------------------
interface ring_sweeper_if;
    import ring_sweeper_pkg::*;

    logic [DATA_W-1:0] ring_dout;
    logic              ring_ready;
    logic [ADDR_W-1:0] ring_index;
    logic [CNT_W-1:0]  ring_count;
    logic              ring_last;
    logic              ring_rd_en;

    modport master (
        output ring_dout,
        output ring_ready,
        output ring_index,
        output ring_count,
        output ring_last,
        input  ring_rd_en
    );

    modport slave (
        input  ring_dout,
        input  ring_ready,
        input  ring_index,
        input  ring_count,
        input  ring_last,
        output ring_rd_en
    );

endinterface

// File: rtl/ring_sweeper_dwell_timer.sv
// ----------------------------------------------------------------------------
// ring_sweeper_dwell_timer
// Down-counter that times how long each tone is held.
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : load the counter with max(i_value, 1)
//   i_value   : dwell length in clock cycles
//   i_pause   : freeze the count (only with RING_SWEEPER_PAUSE_EN)
//   o_expire  : high while the count equals 1 (last dwell cycle)
// Optional feature macro: RING_SWEEPER_PAUSE_EN
// ----------------------------------------------------------------------------
module ring_sweeper_dwell_timer
    import ring_sweeper_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_value,
`ifdef RING_SWEEPER_PAUSE_EN
    input  logic               i_pause,
`endif
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_count;

    // The count parks at zero once it runs out, so it is harmless outside
    // the DWELL state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= clampDwell(i_value);
`ifdef RING_SWEEPER_PAUSE_EN
        end else if (i_pause) begin
            r_count <= r_count;
`endif
        end else if (r_count != '0) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign o_expire = (r_count == DWELL_W'(1));

endmodule

// File: rtl/ring_sweeper.sv
// ----------------------------------------------------------------------------
// ring_sweeper
// Pops tone words from the frequency ring buffer one at a time and holds each
// on the DDS tone output for a programmable dwell, either sweeping the ring
// continuously or making one pass that ends with a done pulse.
//   clk, rst       : clock, asynchronous active-high reset
//   i_enable       : level, 1 = run sweep, 0 = stop
//   i_single       : 1 = one pass then stop, 0 = continuous (sampled at start)
//   i_dwell        : hold cycles per tone, sampled at each load, 0 runs as 1
//   i_pause        : freeze dwell / hold in WAIT (only with RING_SWEEPER_PAUSE_EN)
//   ring           : ring buffer read side (slave modport)
//   o_tone         : current tone word to the DDS
//   o_tone_index   : ring index of the current tone
//   o_tone_valid   : tone output is meaningful
//   o_tone_strobe  : one-cycle pulse when a new tone is loaded
//   o_sweep_done   : one-cycle pulse at the end of a single pass
//   o_busy         : FSM not in IDLE
// Optional feature macro: RING_SWEEPER_PAUSE_EN
// ----------------------------------------------------------------------------
module ring_sweeper
    import ring_sweeper_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic               i_single,
    input  logic [DWELL_W-1:0] i_dwell,
`ifdef RING_SWEEPER_PAUSE_EN
    input  logic               i_pause,
`endif
    ring_sweeper_if.slave      ring,
    output logic [DATA_W-1:0]  o_tone,
    output logic [ADDR_W-1:0]  o_tone_index,
    output logic               o_tone_valid,
    output logic               o_tone_strobe,
    output logic               o_sweep_done,
    output logic               o_busy
);

    logic [2:0] r_state;
    logic [2:0] w_nextState;
    logic       r_singleQ;
    logic       r_lastQ;
    logic       w_pause;
    logic       w_ringHasData;
    logic       w_frontOk;
    logic       w_expire;
    logic       w_loadFire;
    logic       w_popFire;
    logic       w_doneFire;
    logic       w_start;

`ifdef RING_SWEEPER_PAUSE_EN
    assign w_pause = i_pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_ringHasData = ring.ring_ready && (ring.ring_count != '0);
    assign w_frontOk     = w_ringHasData && !w_pause;
    assign w_start       = (r_state == ST_IDLE) && i_enable && (ring.ring_count != '0);
    assign w_loadFire    = (r_state == ST_LOAD) && i_enable;
    assign w_popFire     = (r_state == ST_POP) && i_enable && w_frontOk;
    assign w_doneFire    = (r_state == ST_DWELL) && i_enable && !w_pause &&
                           w_expire && r_singleQ && r_lastQ;

    ring_sweeper_dwell_timer u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_loadFire),
        .i_value  (i_dwell),
`ifdef RING_SWEEPER_PAUSE_EN
        .i_pause  (w_pause),
`endif
        .o_expire (w_expire)
    );

    // SETTLE goes straight to LOAD when the refreshed front is already valid,
    // so a tone is held dwell+3 cycles; WAIT only adds cycles while the ring
    // has nothing to offer. Dropping enable overrides every other transition.
    always_comb begin
        w_nextState = r_state;
        if (!i_enable) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ring.ring_count != '0) w_nextState = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_frontOk) w_nextState = ST_LOAD;
                end
                ST_LOAD: begin
                    w_nextState = ST_DWELL;
                end
                ST_DWELL: begin
                    if (w_expire && !w_pause) begin
                        w_nextState = (r_singleQ && r_lastQ) ? ST_IDLE : ST_POP;
                    end
                end
                ST_POP: begin
                    // A ring that lost its front (write reset) is re-read
                    // from its new front via WAIT instead of being popped.
                    if (!w_pause) begin
                        w_nextState = w_ringHasData ? ST_SETTLE : ST_WAIT;
                    end
                end
                ST_SETTLE: begin
                    w_nextState = w_frontOk ? ST_LOAD : ST_WAIT;
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Tone registers keep their last value when the sweep stops; only the
    // valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_singleQ     <= 1'b0;
            r_lastQ       <= 1'b0;
            o_tone        <= '0;
            o_tone_index  <= '0;
            o_tone_valid  <= 1'b0;
            o_tone_strobe <= 1'b0;
            o_sweep_done  <= 1'b0;
        end else begin
            o_tone_strobe <= w_loadFire;
            o_sweep_done  <= w_doneFire;
            if (w_start) begin
                r_singleQ <= i_single;
            end
            if (w_loadFire) begin
                o_tone       <= ring.ring_dout;
                o_tone_index <= ring.ring_index;
                r_lastQ      <= ring.ring_last;
                o_tone_valid <= 1'b1;
            end else if (!i_enable || w_doneFire) begin
                o_tone_valid <= 1'b0;
            end
        end
    end

    assign ring.ring_rd_en = w_popFire;
    assign o_busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ring_sweeper.sv
// ----------------------------------------------------------------------------
// tb_ring_sweeper
// Directed bench for ring_sweeper with a small four-entry ring model.
// Optional feature macro: RING_SWEEPER_PAUSE_EN (pause tied low here)
// ----------------------------------------------------------------------------
module tb_ring_sweeper;
    import ring_sweeper_pkg::*;

    logic               clk;
    logic               rst;
    logic               enable;
    logic               single;
    logic [DWELL_W-1:0] dwell;
`ifdef RING_SWEEPER_PAUSE_EN
    logic               pause;
`endif
    logic [DATA_W-1:0]  tone;
    logic [ADDR_W-1:0]  toneIndex;
    logic               toneValid;
    logic               toneStrobe;
    logic               sweepDone;
    logic               busy;

    ring_sweeper_if rif ();

    ring_sweeper dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (enable),
        .i_single      (single),
        .i_dwell       (dwell),
`ifdef RING_SWEEPER_PAUSE_EN
        .i_pause       (pause),
`endif
        .ring          (rif),
        .o_tone        (tone),
        .o_tone_index  (toneIndex),
        .o_tone_valid  (toneValid),
        .o_tone_strobe (toneStrobe),
        .o_sweep_done  (sweepDone),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring model: four preloaded entries, front advances (with wrap) on a pop.
    logic [DATA_W-1:0] ringMem [4];
    logic [ADDR_W-1:0] ringIdx;
    logic [CNT_W-1:0]  ringCount;
    logic              ringReady;
    logic              ringRestart;

    assign rif.ring_dout  = ringMem[ringIdx[1:0]];
    assign rif.ring_ready = ringReady;
    assign rif.ring_index = ringIdx;
    assign rif.ring_count = ringCount;
    assign rif.ring_last  = (ringIdx == ADDR_W'(ringCount - CNT_W'(1)));

    initial ringIdx = '0;
    always @(negedge clk) begin
        if (ringRestart) begin
            ringIdx = '0;
        end else if (rif.ring_rd_en) begin
            ringIdx = (ringIdx == ADDR_W'(ringCount - CNT_W'(1))) ? '0 : ringIdx + ADDR_W'(1);
        end
    end

    // Event recorder, sampled on the falling edge.
    int                cycleCount = 0;
    int                rdCount = 0;
    int                doneCount = 0;
    int                doneCycle = 0;
    logic              validAtDone = 1'b1;
    int                strobeCycle [$];
    logic [DATA_W-1:0] strobeTone [$];
    logic [ADDR_W-1:0] strobeIdx [$];

    always @(posedge clk) cycleCount <= cycleCount + 1;

    always @(negedge clk) begin
        if (rif.ring_rd_en) rdCount = rdCount + 1;
        if (sweepDone) begin
            doneCount   = doneCount + 1;
            doneCycle   = cycleCount;
            validAtDone = toneValid;
        end
        if (toneStrobe) begin
            strobeCycle.push_back(cycleCount);
            strobeTone.push_back(tone);
            strobeIdx.push_back(toneIndex);
        end
    end

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic sgl, input logic [DWELL_W-1:0] dw);
        enable = en;
        single = sgl;
        dwell  = dw;
    endtask

    task automatic restartRing();
        ringReady   = 1'b1;
        ringRestart = 1'b1;
        tick();
        ringRestart = 1'b0;
        tick();
    endtask

    // Stops the sweep on the same cycle done is seen so IDLE does not restart.
    task automatic waitDone(input int budget, input string tag);
        int  n;
        bit  found;
        n = 0;
        found = 0;
        while (!found && n < budget) begin
            tick();
            n++;
            if (sweepDone) found = 1;
        end
        enable = 1'b0;
        if (!found) checkOutput(tag, 32'd0, 32'd1);
    endtask

    task automatic waitStrobe(input int wantIdx, input int budget, input string tag);
        int  n;
        bit  found;
        n = 0;
        found = 0;
        while (!found && n < budget) begin
            tick();
            n++;
            if (toneStrobe && (wantIdx < 0 || int'(toneIndex) == wantIdx)) found = 1;
        end
        if (!found) checkOutput(tag, 32'd0, 32'd1);
    endtask

    logic [DATA_W-1:0] expTone [4];
    int base;
    int rdBase;
    int doneBase;
    int nStrobes;

    initial begin
        ringMem[0] = 14'h100;
        ringMem[1] = 14'h200;
        ringMem[2] = 14'h300;
        ringMem[3] = 14'h400;
        expTone[0] = 14'h100;
        expTone[1] = 14'h200;
        expTone[2] = 14'h300;
        expTone[3] = 14'h400;
        rst         = 1'b1;
        ringCount   = 8'd4;
        ringReady   = 1'b1;
        ringRestart = 1'b0;
`ifdef RING_SWEEPER_PAUSE_EN
        pause       = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, 16'd0);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_tone",   32'(tone),           32'd0);
        checkOutput("rst_index",  32'(toneIndex),      32'd0);
        checkOutput("rst_valid",  32'(toneValid),      32'd0);
        checkOutput("rst_strobe", 32'(toneStrobe),     32'd0);
        checkOutput("rst_done",   32'(sweepDone),      32'd0);
        checkOutput("rst_busy",   32'(busy),           32'd0);
        checkOutput("rst_rd_en",  32'(rif.ring_rd_en), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single pass, dwell 5");
        restartRing();
        base = strobeCycle.size(); rdBase = rdCount; doneBase = doneCount;
        applyStimulus(1'b1, 1'b1, 16'd5);
        waitDone(200, "t1_done_timeout");
        checkOutput("t1_busy_at_done", 32'(busy), 32'd0);
        tick();
        nStrobes = strobeCycle.size() - base;
        checkOutput("t1_strobes", 32'(nStrobes), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < strobeCycle.size()) begin
                checkOutput($sformatf("t1_tone%0d", i), 32'(strobeTone[base + i]), 32'(expTone[i]));
                checkOutput($sformatf("t1_idx%0d", i), 32'(strobeIdx[base + i]), 32'(i));
                if (i > 0)
                    checkOutput($sformatf("t1_gap%0d", i),
                                32'(strobeCycle[base + i] - strobeCycle[base + i - 1]), 32'd8);
            end
        end
        checkOutput("t1_rd_en", 32'(rdCount - rdBase), 32'd3);
        checkOutput("t1_done_cnt", 32'(doneCount - doneBase), 32'd1);
        checkOutput("t1_valid_at_done", 32'(validAtDone), 32'd0);
        if (nStrobes > 0)
            checkOutput("t1_done_delay", 32'(doneCycle - strobeCycle[strobeCycle.size() - 1]), 32'd5);
        checkOutput("t1_idle_after", 32'(busy), 32'd0);

        $display("[TB] continuous, dwell 2");
        restartRing();
        base = strobeCycle.size(); doneBase = doneCount;
        applyStimulus(1'b1, 1'b0, 16'd2);
        while (strobeCycle.size() - base < 12 && cycleCount < 2000) tick();
        enable = 1'b0;
        checkOutput("t2_strobes_ge12", 32'(strobeCycle.size() - base >= 12), 32'd1);
        for (int i = 0; i < 12; i++) begin
            if (base + i < strobeCycle.size())
                checkOutput($sformatf("t2_idx%0d", i), 32'(strobeIdx[base + i]), 32'(i % 4));
        end
        if (base + 1 < strobeCycle.size())
            checkOutput("t2_gap", 32'(strobeCycle[base + 1] - strobeCycle[base]), 32'd5);
        if (base + 4 < strobeCycle.size())
            checkOutput("t2_wrap_tone", 32'(strobeTone[base + 4]), 32'h100);
        tick();
        checkOutput("t2_no_done", 32'(doneCount - doneBase), 32'd0);

        $display("[TB] dwell 0 behaves as 1");
        restartRing();
        base = strobeCycle.size(); rdBase = rdCount;
        applyStimulus(1'b1, 1'b1, 16'd0);
        waitDone(100, "t3_done_timeout");
        tick();
        checkOutput("t3_strobes", 32'(strobeCycle.size() - base), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (base + i < strobeCycle.size())
                checkOutput($sformatf("t3_gap%0d", i),
                            32'(strobeCycle[base + i] - strobeCycle[base + i - 1]), 32'd4);
        end
        checkOutput("t3_rd_en", 32'(rdCount - rdBase), 32'd3);

        $display("[TB] enable drop in dwell of entry 2");
        restartRing();
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b1, 16'd5);
        waitStrobe(2, 100, "t4_strobe_timeout");
        tick();
        tick();
        rdBase = rdCount;
        enable = 1'b0;
        tick();
        checkOutput("t4_busy",  32'(busy),      32'd0);
        checkOutput("t4_valid", 32'(toneValid), 32'd0);
        checkOutput("t4_tone",  32'(tone),      32'h300);
        checkOutput("t4_index", 32'(toneIndex), 32'd2);
        repeat (4) tick();
        checkOutput("t4_no_rd_en", 32'(rdCount - rdBase),     32'd0);
        checkOutput("t4_no_done",  32'(doneCount - doneBase), 32'd0);

        $display("[TB] ring_ready drop at pop");
        restartRing();
        applyStimulus(1'b1, 1'b0, 16'd3);
        waitStrobe(1, 100, "t5_strobe_timeout");
        tick();
        tick();
        rdBase = rdCount;
        base = strobeCycle.size();
        ringReady   = 1'b0;
        ringRestart = 1'b1;
        tick();
        ringRestart = 1'b0;
        repeat (4) tick();
        checkOutput("t5_no_rd_en",   32'(rdCount - rdBase),            32'd0);
        checkOutput("t5_busy",       32'(busy),                        32'd1);
        checkOutput("t5_valid_hold", 32'(toneValid),                   32'd1);
        checkOutput("t5_no_strobe",  32'(strobeCycle.size() - base),   32'd0);
        checkOutput("t5_tone_hold",  32'(tone),                        32'h200);
        ringReady = 1'b1;
        waitStrobe(-1, 20, "t5_reload_timeout");
        checkOutput("t5_reload_idx",  32'(toneIndex), 32'd0);
        checkOutput("t5_reload_tone", 32'(tone),      32'h100);
        enable = 1'b0;
        tick();

        $display("[TB] async reset in dwell");
        restartRing();
        applyStimulus(1'b1, 1'b1, 16'd5);
        waitStrobe(-1, 100, "t6_strobe_timeout");
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_tone",   32'(tone),           32'd0);
        checkOutput("t6_index",  32'(toneIndex),      32'd0);
        checkOutput("t6_valid",  32'(toneValid),      32'd0);
        checkOutput("t6_strobe", 32'(toneStrobe),     32'd0);
        checkOutput("t6_done",   32'(sweepDone),      32'd0);
        checkOutput("t6_busy",   32'(busy),           32'd0);
        checkOutput("t6_rd_en",  32'(rif.ring_rd_en), 32'd0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("t6_idle_held", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();
        checkOutput("t6_restart_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
